// File: rtl/vram_pkg.sv
// Shared constants for the dual-port video RAM: read-during-write modes,
// fill engine state encoding and the lane-count helper.
package vram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int lanes(input int dw, input int lane_w);
        return dw / lane_w;
    endfunction

endpackage

// File: rtl/vram_dp_if.sv
// Bus bundle for vram_dp: both RAM ports plus the fill-engine handshake.
interface vram_dp_if
    import vram_pkg::*;
#(
    parameter int DW     = 12,
    parameter int AW     = 19,
    parameter int LANE_W = 4
);
    localparam int LANES = lanes(DW, LANE_W);

    logic             a_en;
    logic             a_we;
    logic [LANES-1:0] a_wmask;
    logic [AW-1:0]    a_addr;
    logic [DW-1:0]    a_din;
    logic [DW-1:0]    a_dout;
    logic             a_dvalid;

    logic             b_en;
    logic             b_we;
    logic [LANES-1:0] b_wmask;
    logic [AW-1:0]    b_addr;
    logic [DW-1:0]    b_din;
    logic [DW-1:0]    b_dout;
    logic             b_dvalid;
    logic             b_ready;

    logic             clr_start;
    logic [DW-1:0]    clr_color;
    logic             clr_busy;
    logic             clr_done;
    logic             collision;

    modport master (
        output a_en, a_we, a_wmask, a_addr, a_din,
        input  a_dout, a_dvalid,
        output b_en, b_we, b_wmask, b_addr, b_din,
        input  b_dout, b_dvalid, b_ready,
        output clr_start, clr_color,
        input  clr_busy, clr_done, collision
    );

    modport slave (
        input  a_en, a_we, a_wmask, a_addr, a_din,
        output a_dout, a_dvalid,
        input  b_en, b_we, b_wmask, b_addr, b_din,
        output b_dout, b_dvalid, b_ready,
        input  clr_start, clr_color,
        output clr_busy, clr_done, collision
    );

endinterface

// File: rtl/vram_fill_fsm.sv
// Frame-clear engine: walks every address once, writing the latched colour
// through port B, and reports busy/done/ready to the host.
module vram_fill_fsm
    import vram_pkg::*;
#(
    parameter int DW    = 12,
    parameter int AW    = 19,
    parameter int DEPTH = 2**AW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          b_ready,
    output logic          fill_we,
    output logic [AW-1:0] fill_addr,
    output logic [DW-1:0] fill_data
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [1:0]    state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] color;

    // State and address counter; start requests outside IDLE are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state <= ST_FILL;
                        cnt   <= '0;
                    end
                end
                ST_FILL: begin
                    if (cnt == LAST) state <= ST_DONE;
                    else             cnt   <= cnt + 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Colour is pure data, captured only when a start is accepted
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && clr_start) color <= clr_color;
    end

    assign clr_busy  = (state == ST_FILL);
    assign clr_done  = (state == ST_DONE);
    assign b_ready   = (state != ST_FILL);
    assign fill_we   = (state == ST_FILL);
    assign fill_addr = cnt;
    assign fill_data = color;

endmodule

// File: rtl/vram_dp.sv
// True dual-port video RAM with lane write masks, selectable read-during-write
// behaviour, optional output register, collision flag and frame-fill engine.
module vram_dp
    import vram_pkg::*;
#(
    parameter int DW       = 12,
    parameter int AW       = 19,
    parameter int DEPTH    = 2**AW,
    parameter int LANE_W   = 4,
    parameter int RDW_MODE = RDW_READ_FIRST,
    parameter int OUT_REG  = 0
)(
    input  logic    clk,
    input  logic    rst_n,
    vram_dp_if.slave bus
);
    localparam int            LANES   = lanes(DW, LANE_W);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic             fill_we, b_ready;
    logic [AW-1:0]    fill_addr;
    logic [DW-1:0]    fill_data;

    logic             pb_rd, pb_wr;
    logic [AW-1:0]    pb_addr;
    logic [DW-1:0]    pb_din;
    logic [LANES-1:0] pb_mask;

    logic             a_inr, b_inr, a_wr, b_wr_raw, b_wr, coll;
    logic [DW-1:0]    a_word, b_word;

    logic [DW-1:0]    a_data_p0, a_data_p1, b_data_p0, b_data_p1;
    logic             a_vld_p0, a_vld_p1, b_vld_p0, b_vld_p1, coll_p0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] din,
                                            input logic [LANES-1:0] mask);
        logic [DW-1:0] w;
        w = old;
        for (int i = 0; i < LANES; i++)
            if (mask[i]) w[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
        return w;
    endfunction

    function automatic logic [DW-1:0] rdw_word(input logic [AW-1:0] ra,
                                               input logic          inr);
        logic [DW-1:0] w;
        w = inr ? mem[ra] : '0;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (b_wr && pb_addr == ra) w = merge(w, pb_din, pb_mask);
            if (a_wr && bus.a_addr == ra) w = merge(w, bus.a_din, bus.a_wmask);
        end
        return w;
    endfunction

    vram_fill_fsm #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (bus.clr_start),
        .clr_color (bus.clr_color),
        .clr_busy  (bus.clr_busy),
        .clr_done  (bus.clr_done),
        .b_ready   (b_ready),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_data (fill_data)
    );

    assign bus.b_ready = b_ready;

    // Port B source select: the fill engine owns the port while it runs
    always_comb begin
        pb_rd   = 1'b0;
        pb_wr   = 1'b1;
        pb_addr = fill_addr;
        pb_din  = fill_data;
        pb_mask = '1;
        if (!fill_we) begin
            pb_rd   = bus.b_en & b_ready;
            pb_wr   = bus.b_en & b_ready & bus.b_we;
            pb_addr = bus.b_addr;
            pb_din  = bus.b_din;
            pb_mask = bus.b_wmask;
        end
    end

    // Range checks, collision detection (A wins) and read-word selection
    always_comb begin
        a_inr    = ({1'b0, bus.a_addr} < DEPTH_L);
        b_inr    = ({1'b0, pb_addr} < DEPTH_L);
        a_wr     = bus.a_en & bus.a_we & a_inr;
        b_wr_raw = pb_wr & b_inr;
        coll     = a_wr & b_wr_raw & (bus.a_addr == pb_addr);
        b_wr     = b_wr_raw & ~coll;
        a_word   = rdw_word(bus.a_addr, a_inr);
        b_word   = rdw_word(pb_addr, b_inr);
    end

    // RAM array writes, lane by lane; never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (a_wr && bus.a_wmask[i])
                mem[bus.a_addr][i*LANE_W +: LANE_W] <= bus.a_din[i*LANE_W +: LANE_W];
            if (b_wr && pb_mask[i])
                mem[pb_addr][i*LANE_W +: LANE_W] <= pb_din[i*LANE_W +: LANE_W];
        end
    end

    // Read data pipe: stage p0 is the RAM read register, p1 the optional output register
    always_ff @(posedge clk) begin
        a_data_p0 <= bus.a_en ? a_word : '0;
        b_data_p0 <= pb_rd ? b_word : '0;
        a_data_p1 <= a_data_p0;
        b_data_p1 <= b_data_p0;
    end

    // Valid flags and collision pulse travel alongside the data pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_p0 <= 1'b0;
            b_vld_p0 <= 1'b0;
            a_vld_p1 <= 1'b0;
            b_vld_p1 <= 1'b0;
            coll_p0  <= 1'b0;
        end else begin
            a_vld_p0 <= bus.a_en;
            b_vld_p0 <= pb_rd;
            a_vld_p1 <= a_vld_p0;
            b_vld_p1 <= b_vld_p0;
            coll_p0  <= coll;
        end
    end

    // Data is gated by its valid so outputs read zero straight out of reset
    assign bus.a_dout    = (OUT_REG != 0) ? (a_vld_p1 ? a_data_p1 : '0) : (a_vld_p0 ? a_data_p0 : '0);
    assign bus.b_dout    = (OUT_REG != 0) ? (b_vld_p1 ? b_data_p1 : '0) : (b_vld_p0 ? b_data_p0 : '0);
    assign bus.a_dvalid  = (OUT_REG != 0) ? a_vld_p1 : a_vld_p0;
    assign bus.b_dvalid  = (OUT_REG != 0) ? b_vld_p1 : b_vld_p0;
    assign bus.collision = coll_p0;

endmodule

// File: tb/tb_vram_dp.sv
// Directed bench for vram_dp: one READ_FIRST/latency-1 instance and one
// WRITE_FIRST/latency-2 instance driven with identical stimulus.
module tb_vram_dp;
    import vram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_en, a_we, b_en, b_we, clr_start;
    logic [2:0]  a_wmask, b_wmask;
    logic [3:0]  a_addr, b_addr;
    logic [11:0] a_din, b_din, clr_color;

    vram_dp_if #(.DW(12), .AW(4), .LANE_W(4)) if0 ();
    vram_dp_if #(.DW(12), .AW(4), .LANE_W(4)) if1 ();

    assign if0.a_en = a_en;           assign if1.a_en = a_en;
    assign if0.a_we = a_we;           assign if1.a_we = a_we;
    assign if0.a_wmask = a_wmask;     assign if1.a_wmask = a_wmask;
    assign if0.a_addr = a_addr;       assign if1.a_addr = a_addr;
    assign if0.a_din = a_din;         assign if1.a_din = a_din;
    assign if0.b_en = b_en;           assign if1.b_en = b_en;
    assign if0.b_we = b_we;           assign if1.b_we = b_we;
    assign if0.b_wmask = b_wmask;     assign if1.b_wmask = b_wmask;
    assign if0.b_addr = b_addr;       assign if1.b_addr = b_addr;
    assign if0.b_din = b_din;         assign if1.b_din = b_din;
    assign if0.clr_start = clr_start; assign if1.clr_start = clr_start;
    assign if0.clr_color = clr_color; assign if1.clr_color = clr_color;

    vram_dp #(.DW(12), .AW(4), .DEPTH(16), .LANE_W(4),
              .RDW_MODE(RDW_READ_FIRST), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));

    vram_dp #(.DW(12), .AW(4), .DEPTH(16), .LANE_W(4),
              .RDW_MODE(RDW_WRITE_FIRST), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int nchk = 0;
    int npass = 0;
    int busy_cyc = 0;
    int done_cnt = 0;
    int bc0, dc0;
    logic [11:0] exp_w [16];

    always @(posedge clk) begin
        if (if0.clr_busy) busy_cyc++;
        if (if0.clr_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; a_wmask = 3'b111; a_addr = 0; a_din = 0;
        b_en = 0; b_we = 0; b_wmask = 3'b111; b_addr = 0; b_din = 0;
        clr_start = 0;
    endtask

    task automatic a_write(input logic [3:0] ad, input logic [11:0] d, input logic [2:0] m);
        a_en = 1; a_we = 1; a_addr = ad; a_din = d; a_wmask = m;
    endtask

    task automatic a_read(input logic [3:0] ad);
        a_en = 1; a_we = 0; a_addr = ad;
    endtask

    // Sweep all 16 words through port A and compare both instances to exp_w
    task automatic read_all(input string tag);
        for (int i = 0; i <= 16; i++) begin
            idle();
            if (i < 16) a_read(4'(i));
            tick();
            if (i < 16) chk($sformatf("%s_d0_w%0d", tag, i), if0.a_dout, exp_w[i]);
            if (i > 0)  chk($sformatf("%s_d1_w%0d", tag, i-1), if1.a_dout, exp_w[i-1]);
        end
        idle();
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 40 && !if0.clr_done; k++) tick();
        chk({tag, "_done"}, if0.clr_done, 1);
        chk({tag, "_done1"}, if1.clr_done, 1);
        chk({tag, "_busy_off"}, if0.clr_busy, 0);
        chk({tag, "_ready_on"}, if0.b_ready, 1);
    endtask

    initial begin
        rst_n = 0; idle(); clr_color = 0;
        #12;
        chk("rst_a_dvalid", if0.a_dvalid, 0);
        chk("rst_a_dout", if0.a_dout, 0);
        chk("rst_b_dvalid", if0.b_dvalid, 0);
        chk("rst_b_ready", if0.b_ready, 1);
        chk("rst_busy", if0.clr_busy, 0);
        chk("rst_done", if0.clr_done, 0);
        chk("rst_coll", if0.collision, 0);
        chk("rst_b_ready1", if1.b_ready, 1);
        rst_n = 1;
        tick();

        // Basic write/read and latency
        a_write(5, 12'h123, 3'b111); tick();
        idle(); tick();
        a_read(5); tick();
        chk("lat_d0_dout", if0.a_dout, 12'h123);
        chk("lat_d0_vld", if0.a_dvalid, 1);
        chk("lat_d1_vld_early", if1.a_dvalid, 0);
        idle(); tick();
        chk("lat_d1_dout", if1.a_dout, 12'h123);
        chk("lat_d1_vld", if1.a_dvalid, 1);
        chk("lat_d0_vld_off", if0.a_dvalid, 0);
        chk("lat_d0_dout_off", if0.a_dout, 0);

        // Lane masks
        a_write(6, 12'hFFF, 3'b111); tick();
        a_write(6, 12'h0A0, 3'b010); tick();
        a_write(6, 12'h555, 3'b000); tick();
        idle(); a_read(6); tick();
        chk("mask_d0", if0.a_dout, 12'hFAF);
        idle(); tick();
        chk("mask_d1", if1.a_dout, 12'hFAF);

        // Cross-port read during write
        a_write(7, 12'h111, 3'b111); tick();
        a_write(7, 12'h222, 3'b111); b_en = 1; b_we = 0; b_addr = 7; tick();
        chk("rdw_d0_first", if0.b_dout, 12'h111);
        chk("rdw_d0_vld", if0.b_dvalid, 1);
        idle(); tick();
        chk("rdw_d1_write_first", if1.b_dout, 12'h222);
        chk("rdw_d1_vld", if1.b_dvalid, 1);

        // Write collision: port A wins
        a_write(9, 12'hAAA, 3'b111);
        b_en = 1; b_we = 1; b_wmask = 3'b111; b_addr = 9; b_din = 12'hBBB;
        tick();
        chk("coll_d0", if0.collision, 1);
        chk("coll_d1", if1.collision, 1);
        idle(); a_read(9); tick();
        chk("coll_d0_off", if0.collision, 0);
        chk("coll_d0_data", if0.a_dout, 12'hAAA);
        idle(); tick();
        chk("coll_d1_data", if1.a_dout, 12'hAAA);

        // Full fill with a dropped B write and a winning A write
        bc0 = busy_cyc; dc0 = done_cnt;
        clr_color = 12'h0F0; clr_start = 1; tick();
        clr_start = 0;
        chk("fill_busy", if0.clr_busy, 1);
        chk("fill_ready", if0.b_ready, 0);
        b_en = 1; b_we = 1; b_wmask = 3'b111; b_addr = 10; b_din = 12'h777;
        tick();
        chk("fill_b_drop_vld", if0.b_dvalid, 0);
        idle(); tick(); tick();
        a_write(3, 12'h555, 3'b111); tick();
        chk("fill_coll", if0.collision, 1);
        idle();
        wait_done("fill");
        tick();
        chk("fill_done_pulse", if0.clr_done, 0);
        chk("fill_busy_cycles", busy_cyc - bc0, 16);
        chk("fill_done_count", done_cnt - dc0, 1);
        for (int i = 0; i < 16; i++) exp_w[i] = (i == 3) ? 12'h555 : 12'h0F0;
        read_all("fill");

        // Reset in the middle of a fill
        dc0 = done_cnt;
        clr_color = 12'h00F; clr_start = 1; tick();
        clr_start = 0;
        repeat (7) tick();
        a_read(0); tick();
        idle();
        rst_n = 0;
        #1;
        chk("mid_busy", if0.clr_busy, 0);
        chk("mid_ready", if0.b_ready, 1);
        chk("mid_vld", if0.a_dvalid, 0);
        chk("mid_dout", if0.a_dout, 0);
        tick();
        chk("mid_vld1", if1.a_dvalid, 0);
        chk("mid_no_done", done_cnt - dc0, 0);
        rst_n = 1;
        tick();
        chk("mid_done_low", if0.clr_done, 0);
        for (int i = 0; i < 16; i++) exp_w[i] = (i < 8) ? 12'h00F : 12'h0F0;
        read_all("mid");

        // Fill restarts cleanly after the aborted one
        clr_color = 12'hABC; clr_start = 1; tick();
        clr_start = 0;
        chk("refill_busy", if0.clr_busy, 1);
        wait_done("refill");
        tick();
        for (int i = 0; i < 16; i++) exp_w[i] = 12'hABC;
        read_all("refill");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
